// File: rtl/intpol2_D4_pkg.sv
// Shared FSM state encodings and coefficient count for the intpol2 D4 sequencer.
// Included first; imported by intpol2_D4_smp_cnt and intpol2_d4_seq_ctrl.
package intpol2_D4_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int COEF_CNT = 3;

endpackage

// File: rtl/intpol2_D4_smp_cnt.sv
// Sample counter for one run; flags when the current count is the final sample.
// One bit wider than the run length so the count can never wrap inside a run.
module intpol2_D4_smp_cnt
  import intpol2_D4_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    inc,
  input  logic [CONFIG_WIDTH-1:0] len,
  output logic                    last
);

  localparam logic [CONFIG_WIDTH:0] ONE = {{CONFIG_WIDTH{1'b0}}, 1'b1};

  logic [CONFIG_WIDTH:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == ({1'b0, len} - ONE));

endmodule

// File: rtl/intpol2_d4_seq_ctrl.sv
// Sequencer for the intpol2 D4 datapath: coefficient load, streaming run, flush, done.
// Optional stall counter enabled by defining INTPOL2_D4_STALL_CNT_EN.
module intpol2_d4_seq_ctrl
  import intpol2_D4_pkg::*;
#(
  parameter int CONFIG_WIDTH   = 32,
  parameter int DATAPATH_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear,
  input  logic                      start,
  input  logic [CONFIG_WIDTH-1:0]   ilen,
  input  logic                      fifo_empty,
  input  logic                      fifo_afull,
  output logic                      busy,
  output logic                      done,
  output logic                      en_M_addr,
  output logic                      Ld_M0,
  output logic                      Ld_M1,
  output logic                      Ld_M2,
  output logic                      Read_Enable,
  output logic                      Write_Enable,
  output logic                      en_sum,
  output logic [DATAPATH_WIDTH-1:0] stall_cnt
);

  localparam logic [COEF_CNT-1:0] LD_FIRST = {{(COEF_CNT-1){1'b0}}, 1'b1};

  logic [2:0]              state_q, state_d;
  logic [COEF_CNT-1:0]     ld_q, ld_d;
  logic [CONFIG_WIDTH-1:0] len_q, len_d;
  logic                    we_q;
  logic                    rd, last, start_acc, cnt_clr;

  assign rd        = (state_q == S_RUN) && !fifo_empty && !fifo_afull;
  assign start_acc = (state_q == S_IDLE) && start && !clear;
  assign cnt_clr   = clear || (state_q == S_DONE) || start_acc;

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ilen != '0) begin
            state_d = S_LOAD;
            len_d   = ilen;
            ld_d    = LD_FIRST;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        // One-hot walk selects the coefficient register; the top bit ends LOAD.
        ld_d = {ld_q[COEF_CNT-2:0], 1'b0};
        if (ld_q[COEF_CNT-1]) state_d = S_RUN;
      end
      S_RUN:   if (rd && last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      ld_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      len_q   <= len_d;
      we_q    <= rd && !clear;
    end
  end

  intpol2_D4_smp_cnt #(
    .CONFIG_WIDTH(CONFIG_WIDTH)
  ) u_smp_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .inc  (rd),
    .len  (len_q),
    .last (last)
  );

  assign busy         = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done         = (state_q == S_DONE);
  assign en_M_addr    = (state_q == S_LOAD);
  assign Ld_M0        = (state_q == S_LOAD) && ld_q[0];
  assign Ld_M1        = (state_q == S_LOAD) && ld_q[1];
  assign Ld_M2        = (state_q == S_LOAD) && ld_q[2];
  assign Read_Enable  = rd;
  assign en_sum       = rd;
  assign Write_Enable = we_q;

`ifdef INTPOL2_D4_STALL_CNT_EN
  localparam logic [DATAPATH_WIDTH-1:0] STALL_ONE = {{(DATAPATH_WIDTH-1){1'b0}}, 1'b1};

  logic [DATAPATH_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clear || start_acc) begin
      stall_d = '0;
    end else if ((state_q == S_RUN) && (fifo_empty || fifo_afull) && (stall_q != '1)) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
